// File: rtl/eth_rx_frame_fifo_if.sv
// AXI-stream byte bus used on both sides of the receive frame buffer.
// The master drives data/valid/last/user and the slave drives ready.
`timescale 1ns/1ps
interface eth_rx_frame_fifo_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward receive frame buffer behind the RGMII MAC.
// Bytes are written speculatively. A good tlast commits the frame. A bad
// frame (tuser on tlast) or an overrun rewinds the write pointer to the
// last commit point, so only whole, error-free frames ever reach the reader.
`timescale 1ns/1ps
module eth_rx_frame_fifo #(
    parameter int DEPTH_P = 4096,
    parameter int CNT_W_P = 16
) (
    input  logic                      rx_clk,
    input  logic                      rx_rst,
    eth_rx_frame_fifo_if.slave        s_axis,
    eth_rx_frame_fifo_if.master       m_axis,
    output logic [CNT_W_P-1:0]        good_frame_count,
    output logic [CNT_W_P-1:0]        bad_frame_count,
    output logic [CNT_W_P-1:0]        overflow_count,
    output logic [$clog2(DEPTH_P):0]  free_bytes
);

    localparam int AW = $clog2(DEPTH_P);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_W = PW'(DEPTH_P);

    typedef enum logic {ST_ACCEPT, ST_DROP} wr_state_t;

    wr_state_t        r_state, w_state_next;
    logic [PW-1:0]    r_wr_ptr, w_wr_ptr_next;
    logic [PW-1:0]    r_commit_ptr, w_commit_ptr_next;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    w_used;
    logic             w_full;
    logic             w_we;
    logic             w_good_inc, w_bad_inc, w_ovf_inc;

    logic [8:0]       r_mem [DEPTH_P];
    logic [8:0]       w_rd_word;

    logic             w_avail, w_ren, w_pop, w_out_free;
    logic             r_out_valid, r_pf_valid;
    logic [8:0]       r_out_word, r_pf_word;

    logic [CNT_W_P-1:0] r_good_cnt, r_bad_cnt, r_ovf_cnt;

    function automatic logic [CNT_W_P-1:0] sat_inc(input logic [CNT_W_P-1:0] v);
        return (v == '1) ? v : v + CNT_W_P'(1);
    endfunction

    // The MAC cannot be stalled.
    assign s_axis.tready = 1'b1;

    // Occupancy counts everything between the reader and the speculative writer.
    assign w_used     = r_wr_ptr - r_rd_ptr;
    assign w_full     = (w_used == DEPTH_W);
    assign free_bytes = DEPTH_W - w_used;

    // Write FSM next-state: store, commit, rewind on bad frame, drop on overrun.
    always_comb begin
        w_state_next      = r_state;
        w_wr_ptr_next     = r_wr_ptr;
        w_commit_ptr_next = r_commit_ptr;
        w_we              = 1'b0;
        w_good_inc        = 1'b0;
        w_bad_inc         = 1'b0;
        w_ovf_inc         = 1'b0;
        case (r_state)
            ST_ACCEPT: begin
                if (s_axis.tvalid) begin
                    if (!w_full) begin
                        w_we          = 1'b1;
                        w_wr_ptr_next = r_wr_ptr + PW'(1);
                        if (s_axis.tlast) begin
                            if (!s_axis.tuser) begin
                                w_commit_ptr_next = r_wr_ptr + PW'(1);
                                w_good_inc        = 1'b1;
                            end else begin
                                w_wr_ptr_next = r_commit_ptr;
                                w_bad_inc     = 1'b1;
                            end
                        end
                    end else if (s_axis.tlast) begin
                        // Overrun on the final beat: drop and recover in one cycle.
                        w_wr_ptr_next = r_commit_ptr;
                        w_ovf_inc     = 1'b1;
                    end else begin
                        w_state_next = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                // tuser is irrelevant here; an overrun frame counts only as overflow.
                if (s_axis.tvalid && s_axis.tlast) begin
                    w_wr_ptr_next = r_commit_ptr;
                    w_ovf_inc     = 1'b1;
                    w_state_next  = ST_ACCEPT;
                end
            end
            default: w_state_next = ST_ACCEPT;
        endcase
    end

    // Write FSM state and write-side pointers.
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            r_state      <= ST_ACCEPT;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
        end else begin
            r_state      <= w_state_next;
            r_wr_ptr     <= w_wr_ptr_next;
            r_commit_ptr <= w_commit_ptr_next;
        end
    end

    // Frame storage, {tlast, tdata} per entry.
    always_ff @(posedge rx_clk) begin
        if (w_we) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {s_axis.tlast, s_axis.tdata};
        end
    end

    // The RAM word is registered straight into the output or prefetch stage,
    // which keeps commit-to-tvalid at one read cycle.
    assign w_rd_word  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_avail    = (r_rd_ptr != r_commit_ptr);
    // Read only while one of the two skid slots is free; ready stays off this path.
    assign w_ren      = w_avail && !(r_out_valid && r_pf_valid);
    assign w_pop      = r_out_valid && m_axis.tready;
    assign w_out_free = w_pop || !r_out_valid;

    // Read pointer plus the two-deep output skid (output stage + prefetch).
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_pf_valid  <= 1'b0;
            r_pf_word   <= '0;
        end else begin
            if (w_ren) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_out_free) begin
                if (r_pf_valid) begin
                    r_out_word  <= r_pf_word;
                    r_out_valid <= 1'b1;
                    r_pf_valid  <= w_ren;
                    if (w_ren) begin
                        r_pf_word <= w_rd_word;
                    end
                end else if (w_ren) begin
                    r_out_word  <= w_rd_word;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_ren) begin
                r_pf_word  <= w_rd_word;
                r_pf_valid <= 1'b1;
            end
        end
    end

    assign m_axis.tvalid = r_out_valid;
    assign m_axis.tdata  = r_out_word[7:0];
    assign m_axis.tlast  = r_out_word[8];
    assign m_axis.tuser  = 1'b0;

    // Saturating frame statistics.
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
            r_ovf_cnt  <= '0;
        end else begin
            if (w_good_inc) r_good_cnt <= sat_inc(r_good_cnt);
            if (w_bad_inc)  r_bad_cnt  <= sat_inc(r_bad_cnt);
            if (w_ovf_inc)  r_ovf_cnt  <= sat_inc(r_ovf_cnt);
        end
    end

    assign good_frame_count = r_good_cnt;
    assign bad_frame_count  = r_bad_cnt;
    assign overflow_count   = r_ovf_cnt;

endmodule
